// File: rtl/avg_channel_scheduler.sv
// Round-robin shared boxcar averager: N_CH signed sample streams, per-channel
// windows of 2^lg2 samples, one tagged average out through a valid/ready port.
module avg_channel_scheduler #(
    parameter int N_CH   = 4,
    parameter int DW     = 13,
    parameter int MAX_LG = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH*DW-1:0]   sample_data,
    output logic [N_CH-1:0]      grant,
    input  logic                 cfg_load,
    input  logic [1:0]           cfg_lg2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [2:0]           out_ch,
    output logic [15:0]          win_count
);

    localparam int AW = DW + MAX_LG;
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = (MAX_LG > 0) ? MAX_LG : 1;

    logic [PW-1:0]          rr_ptr_r;
    logic [1:0]             lg2_r;
    logic signed [AW-1:0]   acc_r [N_CH];
    logic [CW-1:0]          cnt_r [N_CH];
    logic                   out_valid_r;
    logic [DW-1:0]          out_data_r;
    logic [2:0]             out_ch_r;
    logic [15:0]            win_count_r;

    logic [N_CH-1:0]        grant_s;
    logic [PW-1:0]          gnt_idx_s;
    logic                   gnt_any_s;
    logic                   stall_s;
    logic                   xfer_s;
    int                     idx_s;
    logic signed [DW-1:0]   samp_s;
    logic signed [AW-1:0]   sum_s;
    logic signed [AW-1:0]   shifted_s;
    logic [CW-1:0]          cnt_max_s;
    logic                   last_s;

    function automatic logic [1:0] clamp_lg2(input logic [1:0] v);
        if (int'(v) > MAX_LG) begin
            return 2'(MAX_LG);
        end else begin
            return v;
        end
    endfunction

    assign grant     = grant_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign win_count = win_count_r;
    assign xfer_s    = out_valid_r && out_ready;

    // Round-robin arbiter: first requester at or after the pointer, blocked while stalled.
    always_comb begin
        grant_s   = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        idx_s     = 0;
        stall_s   = (out_valid_r && !out_ready) || cfg_load;
        if (!stall_s) begin
            for (int i = 0; i < N_CH; i++) begin
                idx_s = int'(rr_ptr_r) + i;
                idx_s = (idx_s >= N_CH) ? (idx_s - N_CH) : idx_s;
                if (!gnt_any_s && req[idx_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = PW'(idx_s);
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        grant_s[gnt_idx_s] = gnt_any_s;
    end

    // Shared datapath for the granted channel: sign-extended add, floor divide by shift.
    always_comb begin
        samp_s    = sample_data[int'(gnt_idx_s)*DW +: DW];
        sum_s     = acc_r[gnt_idx_s] + AW'(samp_s);
        shifted_s = sum_s >>> lg2_r;
        cnt_max_s = '0;
        for (int i = 0; i < CW; i++) begin
            cnt_max_s[i] = (i < int'(lg2_r)) ? 1'b1 : 1'b0;
        end
        last_s    = (cnt_r[gnt_idx_s] == cnt_max_s);
    end

    // Window state: config load flushes every partial window and wins over grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lg2_r <= 2'd2;
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c] <= '0;
                cnt_r[c] <= '0;
            end
        end else if (cfg_load) begin
            lg2_r <= clamp_lg2(cfg_lg2);
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c] <= '0;
                cnt_r[c] <= '0;
            end
        end else if (gnt_any_s) begin
            if (last_s) begin
                acc_r[gnt_idx_s] <= '0;
                cnt_r[gnt_idx_s] <= '0;
            end else begin
                acc_r[gnt_idx_s] <= sum_s;
                cnt_r[gnt_idx_s] <= cnt_r[gnt_idx_s] + CW'(1);
            end
        end else begin
            lg2_r <= lg2_r;
        end
    end

    // Arbiter pointer moves to the channel after the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (gnt_any_s) begin
            rr_ptr_r <= (int'(gnt_idx_s) == N_CH - 1) ? '0 : gnt_idx_s + PW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Output register: a completing grant can only occur when the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= 3'd0;
        end else if (gnt_any_s && last_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= shifted_s[DW-1:0];
            out_ch_r    <= 3'(gnt_idx_s);
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of averages taken downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count_r <= 16'd0;
        end else if (xfer_s && (win_count_r != 16'hFFFF)) begin
            win_count_r <= win_count_r + 16'd1;
        end else begin
            win_count_r <= win_count_r;
        end
    end

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Directed bench for avg_channel_scheduler: hand-computed averages, grant order,
// stall/handshake behaviour, config flush and mid-window reset.
module tb_avg_channel_scheduler;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [51:0]    sample_data;
    logic [3:0]     grant;
    logic           cfg_load;
    logic [1:0]     cfg_lg2;
    logic           out_valid;
    logic           out_ready;
    logic [12:0]    out_data;
    logic [2:0]     out_ch;
    logic [15:0]    win_count;

    int n_vec;
    int n_err;

    avg_channel_scheduler #(.N_CH(4), .DW(13), .MAX_LG(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .sample_data (sample_data),
        .grant       (grant),
        .cfg_load    (cfg_load),
        .cfg_lg2     (cfg_lg2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .win_count   (win_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int exp_data, input int exp_ch);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(signed'(out_data)), 32'(exp_data));
        chk({tag, " ch"}, 32'(out_ch), 32'(exp_ch));
    endtask

    task automatic set_s(input int c, input int v);
        logic [12:0] t;
        t = 13'(v);
        sample_data[c*13 +: 13] = t;
    endtask

    // Check the combinational grant for this cycle, then advance one clock.
    task automatic step(input logic [3:0] exp_g, input string tag);
        #1;
        chk(tag, 32'(grant), 32'(exp_g));
        tick();
    endtask

    task automatic do_cfg(input logic [1:0] v);
        req      = 4'b0000;
        cfg_load = 1'b1;
        cfg_lg2  = v;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        sample_data = 52'd0;
        cfg_load    = 1'b0;
        cfg_lg2     = 2'd0;
        out_ready   = 1'b1;

        #12;
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst data", 32'(out_data), 32'd0);
        chk("rst ch", 32'(out_ch), 32'd0);
        chk("rst wcnt", 32'(win_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // ch0 alone, default depth 4: (10+20+30+41)/4 = 25
        req = 4'b0001;
        set_s(0, 10); step(4'b0001, "t1 g1");
        set_s(0, 20); step(4'b0001, "t1 g2");
        set_s(0, 30); step(4'b0001, "t1 g3");
        chk("t1 no early out", 32'(out_valid), 32'd0);
        set_s(0, 41); step(4'b0001, "t1 g4");
        chk_out("t1 out", 25, 0);
        req = 4'b0000;
        tick();
        chk("t1 drained", 32'(out_valid), 32'd0);
        chk("t1 wcnt", 32'(win_count), 32'd1);

        // depth 2, all requesting; pointer sits at ch1 after the ch0 grant
        do_cfg(2'd1);
        req = 4'b1111;
        set_s(0, 5); set_s(1, -3); set_s(2, 100); set_s(3, -1);
        step(4'b0010, "t2 r1 ch1"); set_s(1, -4);
        step(4'b0100, "t2 r1 ch2"); set_s(2, 101);
        step(4'b1000, "t2 r1 ch3"); set_s(3, 0);
        step(4'b0001, "t2 r1 ch0"); set_s(0, 7);
        chk("t2 no out after r1", 32'(out_valid), 32'd0);
        step(4'b0010, "t2 r2 ch1"); chk_out("t2 ch1", -4, 1);
        step(4'b0100, "t2 r2 ch2"); chk_out("t2 ch2", 100, 2);
        step(4'b1000, "t2 r2 ch3"); chk_out("t2 ch3", -1, 3);
        step(4'b0001, "t2 r2 ch0"); chk_out("t2 ch0", 6, 0);
        req = 4'b0000;
        tick();
        chk("t2 drained", 32'(out_valid), 32'd0);
        chk("t2 wcnt", 32'(win_count), 32'd5);

        // stall with a held output, then ready rises with a completing grant
        req = 4'b0100; set_s(2, 8);
        step(4'b0100, "t3 ch2 first");
        req = 4'b0010; set_s(1, 20);
        step(4'b0010, "t3 ch1 first");
        set_s(1, 30);
        step(4'b0010, "t3 ch1 second");
        chk_out("t3 ch1 out", 25, 1);
        out_ready = 1'b0;
        req = 4'b0110; set_s(2, 12); set_s(1, 50);
        #1; chk("t3 stall grant a", 32'(grant), 32'd0);
        tick(); chk_out("t3 hold a", 25, 1);
        #1; chk("t3 stall grant b", 32'(grant), 32'd0);
        tick(); chk_out("t3 hold b", 25, 1);
        out_ready = 1'b1;
        step(4'b0100, "t3 ch2 completes");
        chk_out("t3 ch2 out", 10, 2);
        chk("t3 wcnt a", 32'(win_count), 32'd6);
        step(4'b0010, "t3 ch1 partial");
        chk("t3 drained", 32'(out_valid), 32'd0);
        chk("t3 wcnt b", 32'(win_count), 32'd7);

        // extremes at depth 8
        do_cfg(2'd3);
        req = 4'b0010; set_s(1, -4096);
        for (int i = 0; i < 7; i++) step(4'b0010, "t4 neg grant");
        chk("t4 depth 8", 32'(out_valid), 32'd0);
        step(4'b0010, "t4 neg last");
        chk_out("t4 neg", -4096, 1);
        set_s(1, 4095);
        for (int i = 0; i < 8; i++) step(4'b0010, "t4 pos grant");
        chk_out("t4 pos", 4095, 1);
        chk("t4 wcnt a", 32'(win_count), 32'd8);
        req = 4'b0000;
        tick();
        chk("t4 wcnt b", 32'(win_count), 32'd9);

        // cfg_load mid-window drops the partial sum; coincident request is not granted
        do_cfg(2'd2);
        req = 4'b0100; set_s(2, 1);
        step(4'b0100, "t5 ch2 s1");
        step(4'b0100, "t5 ch2 s2");
        cfg_load = 1'b1; cfg_lg2 = 2'd0;
        #1; chk("t5 cfg blocks grant", 32'(grant), 32'd0);
        tick();
        cfg_load = 1'b0;
        set_s(2, 7);
        step(4'b0100, "t5 ch2 depth1");
        chk_out("t5 out", 7, 2);
        req = 4'b0000;
        tick();
        chk("t5 wcnt", 32'(win_count), 32'd10);

        // reset with a held output and partial windows in flight
        do_cfg(2'd2);
        req = 4'b0001; set_s(0, 100);
        step(4'b0001, "t6 ch0 partial");
        req = 4'b1000; set_s(3, 4); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(4'b1000, "t6 ch3 grant");
        chk_out("t6 held", 4, 3);
        req = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("t6 rst grant", 32'(grant), 32'd0);
        chk("t6 rst valid", 32'(out_valid), 32'd0);
        chk("t6 rst data", 32'(out_data), 32'd0);
        chk("t6 rst ch", 32'(out_ch), 32'd0);
        chk("t6 rst wcnt", 32'(win_count), 32'd0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        req = 4'b1001; set_s(0, 2);
        step(4'b0001, "t6 ch0 first");
        req = 4'b0001;
        step(4'b0001, "t6 ch0 s2");
        step(4'b0001, "t6 ch0 s3");
        chk("t6 full depth", 32'(out_valid), 32'd0);
        step(4'b0001, "t6 ch0 s4");
        chk_out("t6 out", 2, 0);
        req = 4'b0000;
        tick();
        chk("t6 wcnt", 32'(win_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
